// File: rtl/mips_instr_encoder.sv
// Packs instruction fields into 32-bit MIPS words for imem loading, one output register stage.
// Optional macro ENC_SHAMT_EN adds a shamt port that fills R-type bits [10:6].
module mips_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
`ifdef ENC_SHAMT_EN
  input  logic [4:0]        shamt,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_sh,
    input logic [5:0]  f_funct,
    input logic [15:0] f_imm
  );
    logic [31:0] w;
    case (op)
      3'd0:    w = {6'h00, f_rs, f_rt, f_rd, f_sh, f_funct};
      3'd1:    w = {6'h23, f_rs, f_rt, f_imm};
      3'd2:    w = {6'h2B, f_rs, f_rt, f_imm};
      3'd3:    w = {6'h04, f_rs, f_rt, f_imm};
      3'd4:    w = {6'h08, f_rs, f_rt, f_imm};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  logic [4:0] shamt_f;
`ifdef ENC_SHAMT_EN
  assign shamt_f = shamt;
`else
  assign shamt_f = 5'd0;
`endif

  logic              vld_p1;
  logic [31:0]       instr_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] addr_nxt;
  logic              err_p1;
  logic [ADDR_W:0]   cnt;

  logic              out_hs;
  logic              accept;
  logic              legal;
  logic [ADDR_W-1:0] addr_load;

  assign in_ready  = !restart && (!vld_p1 || out_ready);
  assign out_hs    = vld_p1 && out_ready && !restart;
  assign accept    = in_valid && in_ready;
  assign legal     = (op_sel <= 3'd4);
  // A word loaded in the same cycle as a handoff takes the address after the departing one.
  assign addr_load = out_hs ? addr_nxt + 1'b1 : addr_nxt;

  // Stage p0 -> p1: field bundle to registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      instr_p1 <= 32'h0;
      addr_p1  <= BASE;
      addr_nxt <= BASE;
      err_p1   <= 1'b0;
      cnt      <= '0;
    end else if (restart) begin
      vld_p1   <= 1'b0;
      addr_p1  <= BASE;
      addr_nxt <= BASE;
      err_p1   <= 1'b0;
      cnt      <= '0;
    end else begin
      err_p1 <= accept && !legal;
      if (out_hs) begin
        addr_nxt <= addr_nxt + 1'b1;
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      if (accept && legal) begin
        vld_p1   <= 1'b1;
        instr_p1 <= encode(op_sel, rs, rt, rd, shamt_f, funct, imm);
        addr_p1  <= addr_load;
      end else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_instr   = instr_p1;
  assign out_addr    = addr_p1;
  assign err_illegal = err_p1;
  assign word_count  = cnt;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized traffic
// against a transaction-level reference model (ENC_SHAMT_EN-aware).
module tb_mips_instr_encoder;

  localparam int AW   = 2;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, restart, in_valid, in_ready, out_valid, out_ready, err_illegal;
  logic [2:0]    op_sel;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic [AW:0]   word_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_addr, m_cnt, m_hs;
  bit          m_err;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
`ifdef ENC_SHAMT_EN
    .shamt(shamt),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  function automatic logic [31:0] ref_word(int op, int f_rs, int f_rt, int f_rd,
                                           int f_sh, int f_funct, int f_imm);
    longint w;
    int opc;
    case (op)
      1: opc = 'h23;
      2: opc = 'h2B;
      3: opc = 'h04;
      4: opc = 'h08;
      default: opc = 0;
    endcase
    if (op == 0)
      w = longint'(f_rs) * (2**21) + f_rt * (2**16) + f_rd * (2**11) + f_sh * (2**6) + f_funct;
    else
      w = longint'(opc) * (2**26) + f_rs * (2**21) + f_rt * (2**16) + f_imm;
    return 32'(w);
  endfunction

  function automatic bit model_ready();
    return !restart && (!m_valid || out_ready);
  endfunction

  // Advance one clock and update the model from the inputs presented this cycle.
  task automatic tick();
    bit hs, acc;
    int sh;
    bit          n_valid = m_valid;
    logic [31:0] n_instr = m_instr;
    int          n_addr = m_addr, n_cnt = m_cnt, n_hs = m_hs;
    bit          n_err = 1'b0;
`ifdef ENC_SHAMT_EN
    sh = int'(shamt);
`else
    sh = 0;
`endif
    hs  = m_valid && out_ready && !restart;
    acc = in_valid && model_ready();
    if (reset) begin
      n_valid = 0; n_instr = 32'h0; n_addr = 0; n_cnt = 0; n_hs = 0;
    end else if (restart) begin
      n_valid = 0; n_addr = 0; n_cnt = 0; n_hs = 0;
    end else begin
      if (hs) begin
        n_hs++;
        if (n_cnt < AMOD) n_cnt++;
      end
      n_err = acc && (op_sel > 3'd4);
      if (acc && op_sel <= 3'd4) begin
        n_valid = 1;
        n_instr = ref_word(int'(op_sel), int'(rs), int'(rt), int'(rd), sh, int'(funct), int'(imm));
        n_addr  = n_hs % AMOD;
      end else if (hs) begin
        n_valid = 0;
      end
    end
    @(posedge clk);
    m_valid = n_valid; m_instr = n_instr; m_addr = n_addr;
    m_cnt = n_cnt; m_hs = n_hs; m_err = n_err;
    #1;
  endtask

  task automatic set_in(bit v, int op, int f_rs, int f_rt, int f_rd, int f_funct, int f_imm);
    in_valid = v; op_sel = 3'(op); rs = 5'(f_rs); rt = 5'(f_rt); rd = 5'(f_rd);
    funct = 6'(f_funct); imm = 16'(f_imm);
  endtask

  task automatic do_reset();
    reset = 1; restart = 0; out_ready = 1; shamt = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", out_instr); end
    n_tests++; if (out_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", out_addr); end
    n_tests++; if (err_illegal !== 1'b0 || word_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_err_cnt got %0b/%0d want 0/0", err_illegal, word_count); end
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_lw();
    do_reset();
    set_in(1, 1, 17, 8, 0, 0, 4);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h8E280004 || out_addr !== 2'd0) begin
      n_fail++; $display("FAIL lw got v=%0b %h @%0d want v=1 8e280004 @0", out_valid, out_instr, out_addr); end
    tick();
    n_tests++; if (out_valid !== 1'b0 || word_count !== 3'd1) begin
      n_fail++; $display("FAIL lw_drain got v=%0b cnt=%0d want v=0 cnt=1", out_valid, word_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(1, 0, 8, 9, 10, 'h20, 0);
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h01095020 || out_addr !== 2'd0) begin
      n_fail++; $display("FAIL b2b_add got v=%0b %h @%0d want v=1 01095020 @0", out_valid, out_instr, out_addr); end
    set_in(1, 2, 17, 8, 0, 0, 8);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %0b want 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'hAE280008 || out_addr !== 2'd1) begin
      n_fail++; $display("FAIL b2b_sw got v=%0b %h @%0d want v=1 ae280008 @1", out_valid, out_instr, out_addr); end
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++; if (out_valid !== 1'b0 || word_count !== 3'd2) begin
      n_fail++; $display("FAIL b2b_drain got v=%0b cnt=%0d want v=0 cnt=2", out_valid, word_count); end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 0;
    set_in(1, 3, 8, 9, 0, 0, 'hFFFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 2, 0, 0, i);
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %0b want 0", i, in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h1109FFFF || out_addr !== 2'd0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%0b %h @%0d want v=1 1109ffff @0", i, out_valid, out_instr, out_addr); end
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1;
    tick();
    n_tests++; if (out_valid !== 1'b0 || word_count !== 3'd1) begin
      n_fail++; $display("FAIL stall_release got v=%0b cnt=%0d want v=0 cnt=1", out_valid, word_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    set_in(1, 6, 3, 4, 5, 6, 7);
    tick();
    n_tests++; if (err_illegal !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse got err=%0b v=%0b want err=1 v=0", err_illegal, out_valid); end
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got %0b want 0", err_illegal); end
    set_in(1, 1, 17, 8, 0, 0, 4);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h8E280004 || out_addr !== 2'd0) begin
      n_fail++; $display("FAIL illegal_next got v=%0b %h @%0d want v=1 8e280004 @0", out_valid, out_instr, out_addr); end
  endtask

  task automatic test_wrap_restart();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 4, 0, 1, 0, 0, i);
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_addr !== 2'(i % 4) || out_instr !== (32'h20010000 | 32'(i))) begin
        n_fail++; $display("FAIL wrap[%0d] got v=%0b %h @%0d want v=1 %h @%0d",
                           i, out_valid, out_instr, out_addr, 32'h20010000 | 32'(i), i % 4); end
    end
    n_tests++; if (word_count !== 3'd4) begin n_fail++; $display("FAIL wrap_cnt4 got %0d want 4", word_count); end
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++; if (word_count !== 3'd4) begin n_fail++; $display("FAIL wrap_sat got %0d want 4", word_count); end
    out_ready = 0;
    set_in(1, 4, 0, 1, 0, 0, 9);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    restart = 1; out_ready = 1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL restart_ready got %0b want 0", in_ready); end
    tick();
    restart = 0;
    n_tests++; if (out_valid !== 1'b0 || out_addr !== 2'd0 || word_count !== 3'd0) begin
      n_fail++; $display("FAIL restart got v=%0b @%0d cnt=%0d want v=0 @0 cnt=0", out_valid, out_addr, word_count); end
  endtask

  task automatic test_shamt();
    logic [31:0] want;
`ifdef ENC_SHAMT_EN
    want = 32'h00095100;
`else
    want = 32'h00095000;
`endif
    do_reset();
    shamt = 5'd4;
    set_in(1, 0, 0, 9, 10, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    shamt = 0;
    n_tests++; if (out_valid !== 1'b1 || out_instr !== want) begin
      n_fail++; $display("FAIL shamt got v=%0b %h want v=1 %h", out_valid, out_instr, want); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(63) == 0);
      restart   = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(9) < 7);
      shamt     = 5'($urandom);
      set_in($urandom_range(1), $urandom_range(7), $urandom_range(31), $urandom_range(31),
             $urandom_range(31), $urandom_range(63), $urandom_range(65535));
      #1;
      exp_rdy = model_ready();
      n_tests++; if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_ready[%0d] got %0b want %0b", c, in_ready, exp_rdy); end
      tick();
      n_tests++; if (out_valid !== m_valid || err_illegal !== m_err || word_count !== (AW+1)'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d] got v=%0b e=%0b cnt=%0d want v=%0b e=%0b cnt=%0d",
                           c, out_valid, err_illegal, word_count, m_valid, m_err, m_cnt); end
      if (m_valid) begin
        n_tests++; if (out_instr !== m_instr || out_addr !== AW'(m_addr)) begin
          n_fail++; $display("FAIL rnd_word[%0d] got %h @%0d want %h @%0d", c, out_instr, out_addr, m_instr, m_addr); end
      end
    end
    reset = 0; restart = 0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_wrap_restart();
    test_shamt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
